// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: valid/ready load handshake between a requester and the scanner
interface seg_scan_ctrl_if;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    modport master (output load_valid, load_data, input load_ready);
    modport slave (input load_valid, load_data, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scanner with frame-synchronous double-buffered loads
module seg_scan_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_ctrl_if.slave     load,
    input  logic               blank_lz,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               frame_start
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [15:0]   disp, pending;
    logic          pending_valid;
    logic          tick, bnd, xfer, blank;
    logic [3:0]    cur;
    logic [6:0]    dec;
    assign tick            = cnt == CW'(TICK_DIV - 1);
    assign bnd             = tick && dig == 2'd3;
    assign load.load_ready = rst_n && !pending_valid;
    assign xfer            = load.load_valid && load.load_ready;
    assign cur             = disp[4*dig +: 4];
    // a digit is a leading zero when it and every digit above it are zero
    assign blank           = blank_lz && dig != 2'd0 && (disp >> {dig, 2'b00}) == 16'h0000;
    always_comb begin
        case (cur)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            dig           <= 2'd0;
            disp          <= 16'h0000;
            pending       <= 16'h0000;
            pending_valid <= 1'b0;
            an            <= 4'b1111;
            seg           <= 7'b1111111;
            frame_start   <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            dig         <= dig + {1'b0, tick};
            frame_start <= bnd;
            an          <= (cnt < CW'(BLANK_CYC)) ? 4'b1111 : ~(4'b0001 << dig);
            seg         <= blank ? 7'b1111111 : dec;
            // accept and commit are exclusive, so a value taken on a boundary waits a frame
            if (xfer) begin
                pending       <= load.load_data;
                pending_valid <= 1'b1;
            end else if (bnd && pending_valid) begin
                disp          <= pending;
                pending_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table vectors, corner sequences and random stimulus against a frame-level model
module tb_seg_scan_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_start;
    int         total = 0, bad = 0;
    seg_scan_ctrl_if lif();
    seg_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .load(lif.slave), .blank_lz(blank_lz),
        .an(an), .seg(seg), .frame_start(frame_start)
    );
    always #5 clk = ~clk;
    logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                             7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    // frame-level model: k is the cycle position within a 32-cycle frame since reset release
    int          k = 0;
    logic [15:0] dm = 0, pm = 0, rest;
    logic        pvm = 0, acc, bnd_m;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fs;
    always @(posedge clk) begin
        if (!rst_n) begin
            k = 0; dm = 0; pm = 0; pvm = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_fs = 0;
        end else begin
            e_an  = (k % 8 < 2) ? 4'hF : ~(4'b0001 << (k / 8));
            rest  = dm >> (4 * (k / 8));
            e_seg = (blank_lz && k / 8 > 0 && rest == 0) ? 7'h7F : dec[rest[3:0]];
            bnd_m = k == 31;
            e_fs  = bnd_m;
            acc   = lif.load_valid && !pvm;
            if (bnd_m && pvm) begin dm = pm; pvm = 0; end
            if (acc) begin pm = lif.load_data; pvm = 1; end
            k = (k + 1) % 32;
        end
        #1;
        chk("model_an", 16'(an), 16'(e_an));
        chk("model_seg", 16'(seg), 16'(e_seg));
        chk("model_fs", 16'(frame_start), 16'(e_fs));
        chk("model_ready", 16'(lif.load_ready), 16'(rst_n && !pvm));
    end
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            lif.load_valid = 1'b0;
            n++;
        end while (!frame_start && n < 80);
        if (!frame_start) chk("fs_timeout", 0, 1);
    endtask
    task automatic wait_ready;
        int n = 0;
        while (!lif.load_ready && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!lif.load_ready) chk("ready_timeout", 0, 1);
    endtask
    // call on a frame_start cycle; checks the 32 output cycles of the frame that follows
    task automatic check_frame(input string nm, input logic [3:0][6:0] e);
        logic [3:0] ea;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            if (j == 1) lif.load_valid = 1'b0;
            ea = ((j - 1) % 8 < 2) ? 4'hF : ~(4'b0001 << ((j - 1) / 8));
            chk({nm, "_an"}, 16'(an), 16'(ea));
            chk({nm, "_seg"}, 16'(seg), 16'(e[(j - 1) / 8]));
        end
        chk({nm, "_fs"}, 16'(frame_start), 16'h1);
    endtask
    typedef struct {
        logic [15:0]     data;
        logic            blz;
        logic [3:0][6:0] e;
    } vec_t;
    vec_t tbl [7];
    int   n;
    initial begin
        tbl[0] = '{16'h1234, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        tbl[1] = '{16'h0070, 1'b1, {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}};
        tbl[2] = '{16'h0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        tbl[3] = '{16'hABCD, 1'b0, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
        tbl[4] = '{16'h0070, 1'b0, {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}};
        tbl[5] = '{16'h0305, 1'b1, {7'b1111111, 7'b0110000, 7'b1000000, 7'b0010010}};
        tbl[6] = '{16'h9F08, 1'b1, {7'b0010000, 7'b0111111, 7'b1000000, 7'b0000000}};
        lif.load_valid = 1'b0;
        lif.load_data  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_ready", 16'(lif.load_ready), 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 16'(lif.load_ready), 16'h1);
        wait_fs(n);
        chk("first_frame_delay", 16'(n), 16'd31);
        for (int i = 0; i < 7; i++) begin
            blank_lz = tbl[i].blz;
            wait_ready();
            lif.load_valid = 1'b1;
            lif.load_data  = tbl[i].data;
            wait_fs(n);
            wait_fs(n);
            check_frame($sformatf("tbl%0d", i), tbl[i].e);
        end
        blank_lz = 1'b0;
        wait_ready();
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h1111;
        @(negedge clk);
        lif.load_data  = 16'h5678;
        chk("bp_ready0", 16'(lif.load_ready), 16'h0);
        n = 0;
        while (!lif.load_ready && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("bp_ready_rise", 16'(lif.load_ready), 16'h1);
        chk("bp_fs", 16'(frame_start), 16'h1);
        check_frame("bp_old", {4{7'b1111001}});
        check_frame("bp_new", {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000});
        repeat (31) @(negedge clk);
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h9999;
        @(negedge clk);
        chk("sc_fs", 16'(frame_start), 16'h1);
        lif.load_valid = 1'b0;
        check_frame("sc_old", {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000});
        check_frame("sc_new", {4{7'b0010000}});
        wait_ready();
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h4444;
        @(negedge clk);
        lif.load_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("ra_ready", 16'(lif.load_ready), 16'h0);
        chk("ra_an", 16'(an), 16'hF);
        chk("ra_seg", 16'(seg), 16'h7F);
        rst_n = 1'b1;
        wait_fs(n);
        chk("ra_delay", 16'(n), 16'd32);
        check_frame("ra_f0", {4{7'b1000000}});
        check_frame("ra_f1", {4{7'b1000000}});
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            lif.load_valid = $urandom_range(0, 2) == 0;
            case ($urandom_range(0, 3))
                0: lif.load_data = 16'($urandom);
                1: lif.load_data = 16'($urandom) & 16'h00FF;
                2: lif.load_data = 16'($urandom) & 16'h000F;
                default: lif.load_data = 16'($urandom) & 16'h0F0F;
            endcase
            if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
            rst_n = $urandom_range(0, 299) != 0;
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
